// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing.
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module mc_main_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
`ifdef MC_CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
`endif

  logic [3:0] state_r;
  logic [3:0] state_nxt;
  logic       illegal_r;
  logic       set_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_FETCH;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      if (set_illegal) illegal_r <= 1'b1;
    end
  end

  // Opcode is only consulted in DECODE and MEMADR, where the IR is frozen.
  always_comb begin
    state_nxt   = S_FETCH;
    set_illegal = 1'b0;
    case (state_r)
      S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_nxt = S_ADDIEX;
`endif
          default: begin
            state_nxt   = S_FETCH;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_nxt = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: state_nxt = S_ADDIWB;
`endif
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Reset gates every control output so nothing pending can complete.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    instr_done  = 1'b0;
    if (rst_n) begin
      case (state_r)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: ALUSrcB = 2'b11;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
`ifdef MC_CTRL_ADDI_EN
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state      = state_r;
  assign illegal_op = illegal_r;

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: per-instruction expected cycle scripts built from the
// instruction-level behaviour, compared cycle by cycle against the DUT.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
  logic [1:0] ALUSrcB, PCSource, ALUOp;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUOp(ALUOp), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] srcb, psrc, aop;
    logic       done;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       c;
    logic       rdy;
    bit         sets_ill;
  } step_t;

  ctl_t act;
  assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, ALUSrcB, PCSource, ALUOp,
                instr_done};

  step_t exp_q[$];
  bit    ill_exp;
  int    vectors = 0;
  int    miscompares = 0;

`ifdef MC_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) ||
           (op == 6'd2) || (ADDI_EN && op == 6'd8);
  endfunction

  task automatic push(input logic [3:0] st, input ctl_t c, input logic rdy, input bit ill);
    step_t s;
    s.st = st; s.c = c; s.rdy = rdy; s.sets_ill = ill;
    exp_q.push_back(s);
  endtask

  // Expected per-cycle script for one instruction, with stall counts in fetch and memory.
  task automatic build(input logic [5:0] op, input int fst, input int mst);
    ctl_t c;
    exp_q.delete();
    for (int i = 0; i <= fst; i++) begin
      c = '0; c.mrd = 1'b1; c.srcb = 2'b01;
      if (i == fst) begin c.irw = 1'b1; c.pcw = 1'b1; end
      push(4'd0, c, (i == fst), 1'b0);
    end
    c = '0; c.srcb = 2'b11;
    push(4'd1, c, 1'($urandom), !is_legal(op));
    if (is_legal(op)) begin
      case (op)
        6'd35, 6'd43: begin
          c = '0; c.srca = 1'b1; c.srcb = 2'b10;
          push(4'd2, c, 1'($urandom), 1'b0);
          for (int i = 0; i <= mst; i++) begin
            c = '0; c.iord = 1'b1;
            if (op == 6'd35) c.mrd = 1'b1;
            else begin c.mwr = 1'b1; c.done = (i == mst); end
            push((op == 6'd35) ? 4'd3 : 4'd5, c, (i == mst), 1'b0);
          end
          if (op == 6'd35) begin
            c = '0; c.rw = 1'b1; c.m2r = 1'b1; c.done = 1'b1;
            push(4'd4, c, 1'($urandom), 1'b0);
          end
        end
        6'd0: begin
          c = '0; c.srca = 1'b1; c.aop = 2'b10;
          push(4'd6, c, 1'($urandom), 1'b0);
          c = '0; c.rw = 1'b1; c.rdst = 1'b1; c.done = 1'b1;
          push(4'd7, c, 1'($urandom), 1'b0);
        end
        6'd4: begin
          c = '0; c.srca = 1'b1; c.aop = 2'b01; c.pcwc = 1'b1; c.psrc = 2'b01; c.done = 1'b1;
          push(4'd8, c, 1'($urandom), 1'b0);
        end
        6'd2: begin
          c = '0; c.pcw = 1'b1; c.psrc = 2'b10; c.done = 1'b1;
          push(4'd9, c, 1'($urandom), 1'b0);
        end
        default: begin
          c = '0; c.srca = 1'b1; c.srcb = 2'b10;
          push(4'd10, c, 1'($urandom), 1'b0);
          c = '0; c.rw = 1'b1; c.done = 1'b1;
          push(4'd11, c, 1'($urandom), 1'b0);
        end
      endcase
    end
  endtask

  // Play the script; abort_at >= 0 asserts reset at that step instead.
  task automatic run(input string name, input logic [5:0] op, input int fst,
                     input int mst, input int abort_at);
    int dones = 0;
    int exp_len;
    build(op, fst, mst);
    exp_len = exp_q.size();
    for (int i = 0; i < exp_len; i++) begin
      @(negedge clk);
      if (i == abort_at) begin
        rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        vectors++;
        if (state !== 4'd0 || act !== ctl_t'(0) || illegal_op !== 1'b0) begin
          miscompares++;
          $display("FAIL %s abort step %0d: state=%0d ctl=%h ill=%b, want state=0 ctl=0 ill=0",
                   name, i, state, act, illegal_op);
        end
        ill_exp = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      mem_ready = exp_q[i].rdy;
      opcode    = (exp_q[i].st == 4'd0) ? 6'($urandom) : op;
      #1;
      vectors++;
      if (state !== exp_q[i].st) begin
        miscompares++;
        $display("FAIL %s step %0d state: got %0d want %0d", name, i, state, exp_q[i].st);
      end
      vectors++;
      if (act !== exp_q[i].c) begin
        miscompares++;
        $display("FAIL %s step %0d controls (st %0d): got %h want %h",
                 name, i, exp_q[i].st, act, exp_q[i].c);
      end
      vectors++;
      if (illegal_op !== ill_exp) begin
        miscompares++;
        $display("FAIL %s step %0d illegal_op: got %b want %b", name, i, illegal_op, ill_exp);
      end
      if (instr_done === 1'b1) dones++;
      if (exp_q[i].sets_ill) ill_exp = 1'b1;
    end
    vectors++;
    if (dones != (is_legal(op) ? 1 : 0)) begin
      miscompares++;
      $display("FAIL %s instr_done pulses: got %0d want %0d", name, dones, is_legal(op) ? 1 : 0);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd35;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      vectors++;
      if (state !== 4'd0 || act !== ctl_t'(0) || illegal_op !== 1'b0) begin
        miscompares++;
        $display("FAIL reset cycle %0d: state=%0d ctl=%h ill=%b, want all 0", i, state, act, illegal_op);
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    ill_exp = 1'b0;
    run("first_after_reset", 6'd2, 0, 0, -1);
  endtask

  task automatic test_lw;
    run("lw", 6'd35, 0, 0, -1);
    run("lw_stall", 6'd35, 2, 3, -1);
  endtask

  task automatic test_rtype;
    run("rtype", 6'd0, 0, 0, -1);
  endtask

  task automatic test_branch_jump;
    run("beq", 6'd4, 0, 0, -1);
    run("j", 6'd2, 1, 0, -1);
  endtask

  task automatic test_sw_stall;
    run("sw_stall", 6'd43, 0, 2, -1);
    run("sw", 6'd43, 0, 0, -1);
  endtask

  task automatic test_illegal;
    run("illegal63", 6'd63, 0, 0, -1);
    run("rtype_after_illegal", 6'd0, 0, 0, -1);
    run("addi", 6'd8, 0, 0, -1);
  endtask

  task automatic test_reset_abort;
    run("abort_sw", 6'd43, 0, 1, 3);
    run("after_abort", 6'd35, 0, 0, -1);
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd63, 6'd17};
    for (int n = 0; n < 60; n++)
      run("random", ops[$urandom_range(0, 7)], $urandom_range(0, 3), $urandom_range(0, 3), -1);
  endtask

  initial begin
    rst_n = 1'b1; mem_ready = 1'b0; opcode = 6'd0; ill_exp = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_branch_jump();
    test_sw_stall();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mc_main_control.md
# mc_main_control

Multi-cycle main control unit for the MIPS datapath: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It sits directly upstream of the ALU control block and drives its 2-bit `ALUOp` input. It also drives every other datapath enable and mux select. Memory accesses stall on a ready handshake, and unknown opcodes raise a sticky error flag.

## Interface
- `OP_RTYPE`, 6'd0, R-type opcode
- `OP_LW`, 6'd35, load word opcode
- `OP_SW`, 6'd43, store word opcode
- `OP_BEQ`, 6'd4, branch-equal opcode
- `OP_J`, 6'd2, jump opcode
- `OP_ADDI`, 6'd8, add-immediate opcode (used only with `MC_CTRL_ADDI_EN`)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `opcode`  in  6  instruction register bits [31:26]
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `ALUSrcA`, `RegWrite`, `RegDst`  out  1 each  datapath controls
- `ALUSrcB`  out  2  ALU B select: 00 reg, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `PCSource`  out  2  00 ALU result, 01 ALUOut, 10 jump target
- `ALUOp`  out  2  to ALU control: 00 add, 01 sub, 10 funct
- `instr_done`  out  1  one-cycle pulse in the final state of each instruction
- `illegal_op`  out  1  sticky unknown-opcode flag
- `state`  out  4  current state encoding, debug only

## Operation
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11
- Outputs are Moore-decoded from `state`, except where noted.
- Any output not listed for a state is 0 in that state.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal `mem_ready`.
  - Advances to DECODE when `mem_ready`=1; otherwise holds.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: lw/sw→MEMADR, R→EXEC, beq→BRANCH, j→JUMP, addi→ADDIEX.
  - Any other opcode → FETCH, and `illegal_op` is set.
- MEMADR:
  - Drives ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: lw→MEMRD, sw→MEMWR.
- MEMRD:
  - Drives MemRead=1, IorD=1.
  - Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, `instr_done`=1; then FETCH.
- MEMWR:
  - Drives MemWrite=1, IorD=1.
  - `instr_done` equals `mem_ready`.
  - Holds until `mem_ready`, then goes to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, `instr_done`=1; then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, `instr_done`=1; then FETCH.
- JUMP: PCWrite=1, PCSource=10, `instr_done`=1; then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, `instr_done`=1; then FETCH.
- Opcode is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite=0 outside FETCH.
- Unreachable state encodings (12-15) → FETCH on the next edge. All outputs are 0 while in them.

## Timing
- Reset:
  - While `rst_n`=0, `state`=FETCH and `illegal_op`=0.
  - All control outputs and `instr_done` are forced to 0, gated by `rst_n`.
  - The first FETCH output appears after `rst_n` rises.
- Reset asserted mid-instruction aborts immediately, with no pending write completing.
- Minimum cycles per instruction, with `mem_ready` always 1:
  - lw 5, sw 4, R 4, addi 4, beq 3, j 3
  - illegal opcode 2 (FETCH, DECODE)
- Each low cycle of `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is ignored in all other states.
- `illegal_op` rises on the clock edge leaving DECODE. It stays 1 until reset; later legal instructions do not clear it.
- `ALUOp` is valid in the same cycle as its state. The downstream ALU control is combinational, so the ALU operation settles within that cycle.

## Configuration
- `MC_CTRL_ADDI_EN` defined: opcode 8 follows DECODE→ADDIEX→ADDIWB→FETCH.
- Not defined:
  - ADDIEX and ADDIWB are not implemented.
  - Opcode 8 is illegal: it sets `illegal_op` and returns to FETCH after DECODE.
  - Encodings 10 and 11 become unreachable.

## Test plan
- Reset with `rst_n`=0 for 3 cycles, `mem_ready`=1 → all outputs 0, `state`=0; first cycle after release: MemRead=1, ALUSrcB=01, IRWrite=1, PCWrite=1.
- Opcode 35, `mem_ready`=1 → state sequence 0,1,2,3,4, then 0. In state 4: RegWrite=1, MemtoReg=1. `instr_done` pulses once.
- Opcode 0 → in EXEC, ALUOp=10 and ALUSrcB=00. In ALUWB, RegDst=1 and RegWrite=1. Total 4 cycles.
- Opcode 4 → in BRANCH, ALUOp=01, PCWriteCond=1, PCSource=01. Opcode 2 → in JUMP, PCWrite=1, PCSource=10. Each takes 3 cycles.
- Opcode 43 with `mem_ready` low for 2 cycles in MEMWR → MemWrite held for 3 cycles. `instr_done` only on the ready cycle. Total 6 cycles.
- Opcode 63 → `illegal_op` set after DECODE; a following opcode 0 completes normally with `illegal_op` still 1. Opcode 8 is legal with `MC_CTRL_ADDI_EN` (4 cycles) and illegal without it.
